// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges an in-order pipeline and a multi-cycle unit onto one
// register-file write port, with a one-entry result buffer and starvation guard.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [63:0] mc_data,
  output logic        mc_ready,
  output logic        pipe_stall,
  output logic [63:0] write_back_data,
  output logic [4:0]  write_back_addr,
  output logic        reg_write_back
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [4:0]  buf_rd_r, buf_rd_nxt_s;
  logic [63:0] buf_data_r, buf_data_nxt_s;
  logic        pipe_req_s;
  logic        grant_s;
  logic [4:0]  grant_rd_s;
  logic [63:0] grant_data_s;

  // x0 writes are architecturally void, so they never compete for the port
  assign pipe_req_s = pipe_valid && (pipe_rd != 5'd0);
  assign cnt_inc_s  = cnt_r + 4'd1;
  assign mc_ready   = (state_r == IDLE);
  assign pipe_stall = (state_r == FORCE);

  // Next-state, buffer update and writeback grant selection
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    buf_rd_nxt_s   = buf_rd_r;
    buf_data_nxt_s = buf_data_r;
    grant_s        = 1'b0;
    grant_rd_s     = pipe_rd;
    grant_data_s   = pipe_data;
    case (state_r)
      IDLE: begin
        grant_s = pipe_req_s;
        if (mc_valid && (mc_rd != 5'd0)) begin
          buf_rd_nxt_s   = mc_rd;
          buf_data_nxt_s = mc_data;
          cnt_nxt_s      = 4'd0;
          state_nxt_s    = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING: begin
        grant_s = 1'b1;
        if (!pipe_req_s) begin
          grant_rd_s   = buf_rd_r;
          grant_data_s = buf_data_r;
          state_nxt_s  = IDLE;
        end else if (pipe_rd != buf_rd_r) begin
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = (cnt_inc_s == LIMIT) ? FORCE : PENDING;
        end else begin
          // younger pipeline write to the same register supersedes the buffer
          state_nxt_s = IDLE;
        end
      end
      FORCE: begin
        grant_s      = 1'b1;
        grant_rd_s   = buf_rd_r;
        grant_data_s = buf_data_r;
        state_nxt_s  = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Arbiter state, starve counter and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      buf_rd_r   <= 5'd0;
      buf_data_r <= 64'd0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      buf_rd_r   <= buf_rd_nxt_s;
      buf_data_r <= buf_data_nxt_s;
    end
  end

  // Registered register-file write port; address and data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_back  <= 1'b0;
      write_back_addr <= 5'd0;
      write_back_data <= 64'd0;
    end else begin
      reg_write_back <= grant_s;
      if (grant_s) begin
        write_back_addr <= grant_rd_s;
        write_back_data <= grant_data_s;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (STARVE_LIMIT = 4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [63:0] mc_data;
  logic        mc_ready;
  logic        pipe_stall;
  logic [63:0] write_back_data;
  logic [4:0]  write_back_addr;
  logic        reg_write_back;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [63:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] md;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        ready;
    logic        stall;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .pipe_stall(pipe_stall),
    .write_back_data(write_back_data), .write_back_addr(write_back_addr),
    .reg_write_back(reg_write_back)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [63:0] pd,
                              logic mv, logic [4:0] mrd, logic [63:0] md,
                              logic we, logic [4:0] addr, logic [63:0] data,
                              logic ready, logic stall);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.we = we; v.addr = addr; v.data = data; v.ready = ready; v.stall = stall;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic we, logic [4:0] addr, logic [63:0] data,
                         logic ready, logic stall);
    chk({tag, ".we"},    {63'd0, reg_write_back}, {63'd0, we});
    chk({tag, ".addr"},  {59'd0, write_back_addr}, {59'd0, addr});
    chk({tag, ".data"},  write_back_data, data);
    chk({tag, ".ready"}, {63'd0, mc_ready}, {63'd0, ready});
    chk({tag, ".stall"}, {63'd0, pipe_stall}, {63'd0, stall});
  endtask

  task automatic drive(logic pv, logic [4:0] prd, logic [63:0] pd,
                       logic mv, logic [4:0] mrd, logic [63:0] md);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // pipeline-only write, then idle hold
    vecs[0]  = mk(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0,  1'b1, 5'd5, 64'hAA, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 64'hAA, 1'b1, 1'b0);
    // simultaneous pipeline + mc in IDLE
    vecs[2]  = mk(1'b1, 5'd3, 64'h11, 1'b1, 5'd7, 64'h22, 1'b1, 5'd3, 64'h11, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h22, 1'b1, 1'b0);
    // x0 filtering on both sources
    vecs[4]  = mk(1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66, 1'b0, 5'd7, 64'h22, 1'b1, 1'b0);
    // starvation: accept x9, four pipeline writes, FORCE, buffer write, resume
    vecs[5]  = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd9, 64'h99, 1'b0, 5'd7, 64'h22, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 5'd4, 64'h41, 1'b0, 5'd0, 64'h0,  1'b1, 5'd4, 64'h41, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 5'd4, 64'h42, 1'b0, 5'd0, 64'h0,  1'b1, 5'd4, 64'h42, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 5'd4, 64'h43, 1'b0, 5'd0, 64'h0,  1'b1, 5'd4, 64'h43, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0,  1'b1, 5'd4, 64'h44, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 5'd4, 64'h45, 1'b0, 5'd0, 64'h0,  1'b1, 5'd9, 64'h99, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 5'd4, 64'h45, 1'b0, 5'd0, 64'h0,  1'b1, 5'd4, 64'h45, 1'b1, 1'b0);
    // cancel: buffered x6 superseded by pipeline x6
    vecs[12] = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd6, 64'h1,  1'b0, 5'd4, 64'h45, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 5'd6, 64'h2,  1'b0, 5'd0, 64'h0,  1'b1, 5'd6, 64'h2,  1'b1, 1'b0);
    vecs[14] = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd6, 64'h2,  1'b1, 1'b0);
    // mc offer while PENDING is not accepted
    vecs[15] = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd8, 64'h8,  1'b0, 5'd6, 64'h2,  1'b0, 1'b0);
    vecs[16] = mk(1'b0, 5'd0, 64'h0,  1'b1, 5'd10, 64'hA, 1'b1, 5'd8, 64'h8,  1'b1, 1'b0);
    vecs[17] = mk(1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd8, 64'h8,  1'b1, 1'b0);

    rst = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #2 rst = 1'b1;
    #1 chk_out("reset", 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
              vecs[i].ready, vecs[i].stall);
    end

    // Async reset while in FORCE drops the buffered x12 write
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd12, 64'hC);
    step();
    chk_out("force_acc", 1'b0, 5'd8, 64'h8, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd4, 64'h50 + 64'(k), 1'b0, 5'd0, 64'h0);
      step();
    end
    chk_out("force_state", 1'b1, 5'd4, 64'h53, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("post_rst%0d", k), 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    end
    drive(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'h0);
    step();
    chk_out("post_rst_wr", 1'b1, 5'd2, 64'h22, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
